// File: rtl/axi8_stream_register_pkg.sv
// Shared types for the 8-bit stream register slice.
// Holds the beat record (payload + last flag) and the default width.
package axi8_stream_register_pkg;

   localparam int DATA_W = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic two-entry skid slice: output register plus one skid register.
// Ports: in_data/in_valid/in_ready upstream, out_data/out_valid/out_ready down.
module axis_skid_buffer
   import axi8_stream_register_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] skid_data;
   logic         skid_valid;
   logic         out_load;
   logic         in_xfer;

   // in_ready comes straight from a flop, so no comb path to out_ready.
   assign in_ready = !skid_valid;
   assign in_xfer  = in_valid && in_ready;
   assign out_load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (out_load) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         // output stalled: park the beat that was already in flight
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/axi8_stream_register.sv
// 8-bit stream register slice with fixed-length packet framing.
// Ports: data_in/m_valid/m_ready/m_last upstream; s_data/s_valid/s_ready/s_last downstream.
module axi8_stream_register
   import axi8_stream_register_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int PACKET_LEN = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  m_valid,
   output logic                  m_ready,
   output logic                  m_last,
   output logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_valid,
   input  logic                  s_ready,
   output logic                  s_last
);

   localparam int CW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_LEN - 1);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] count;
   logic          last_q;
   logic          accept;
   beat_t         in_beat;
   beat_t         out_beat;

   assign accept = m_valid && m_ready;

   // last_q mirrors (count == LAST_IDX) as a flop so m_last is registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= '0;
         last_q <= (LAST_IDX == '0);
      end else if (accept) begin
         if (count == LAST_IDX) begin
            count  <= '0;
            last_q <= (LAST_IDX == '0);
         end else begin
            count  <= count + ONE;
            last_q <= ((count + ONE) == LAST_IDX);
         end
      end
   end

   assign m_last       = last_q;
   assign in_beat.data = data_in;
   assign in_beat.last = last_q;

   axis_skid_buffer #(
      .W($bits(beat_t))
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_beat),
      .in_valid (m_valid),
      .in_ready (m_ready),
      .out_data (out_beat),
      .out_valid(s_valid),
      .out_ready(s_ready)
   );

   assign s_data = out_beat.data;
   assign s_last = out_beat.last;

endmodule

// File: tb/tb_axi8_stream_register.sv
// Self-checking bench for axi8_stream_register.
// Table vectors, hand sequences and a queue reference model.
module tb_axi8_stream_register;

   localparam int LEN = 4;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       s_last;

   int total = 0;
   int bad = 0;

   axi8_stream_register #(
      .DATA_WIDTH(8),
      .PACKET_LEN(LEN)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .data_in(data_in),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_last (m_last),
      .s_data (s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_last (s_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of held beats, at most two.
   typedef struct {
      logic [7:0] d;
      logic       l;
   } mb_t;

   mb_t q[$];
   int  acc = 0;
   int  acc_all = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         acc = 0;
      end else begin
         bit ms;
         bit ss;
         ms = m_valid && (q.size() < 2);
         ss = s_ready && (q.size() > 0);
         if (ss) void'(q.pop_front());
         if (ms) begin
            q.push_back('{data_in, (acc % LEN) == LEN - 1});
            acc++;
            acc_all++;
         end
      end
   end

   // Continuous comparison against the model, mid-cycle.
   logic       hold;
   logic [7:0] hold_d;
   logic       hold_l;

   always @(negedge clk) begin
      if (!rst) begin
         hold = 1'b0;
      end else begin
         chk("mdl_s_valid", int'(s_valid), int'(q.size() > 0));
         chk("mdl_m_ready", int'(m_ready), int'(q.size() < 2));
         chk("mdl_m_last", int'(m_last), int'((acc % LEN) == LEN - 1));
         if (q.size() > 0) begin
            chk("mdl_s_data", int'(s_data), int'(q[0].d));
            chk("mdl_s_last", int'(s_last), int'(q[0].l));
         end
         if (hold) begin
            chk("stable_valid", int'(s_valid), 1);
            chk("stable_data", int'(s_data), int'(hold_d));
            chk("stable_last", int'(s_last), int'(hold_l));
         end
         hold   = s_valid && !s_ready;
         hold_d = s_data;
         hold_l = s_last;
      end
   end

   typedef struct {
      logic       mv;
      logic [7:0] d;
      logic       sr;
      logic       ev;
      logic [7:0] ed;
      logic       el;
      logic       emr;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int start;
      bit done;

      tbl[0]  = '{1, 8'h24, 1, 1, 8'h24, 0, 1};
      tbl[1]  = '{1, 8'h81, 1, 1, 8'h81, 0, 1};
      tbl[2]  = '{1, 8'h09, 1, 1, 8'h09, 0, 1};
      tbl[3]  = '{1, 8'h63, 1, 1, 8'h63, 1, 1};
      tbl[4]  = '{1, 8'hA0, 0, 1, 8'h63, 1, 0};
      tbl[5]  = '{1, 8'hA1, 0, 1, 8'h63, 1, 0};
      tbl[6]  = '{1, 8'hA2, 0, 1, 8'h63, 1, 0};
      tbl[7]  = '{1, 8'hA3, 0, 1, 8'h63, 1, 0};
      tbl[8]  = '{1, 8'hA4, 0, 1, 8'h63, 1, 0};
      tbl[9]  = '{1, 8'hA5, 1, 1, 8'hA0, 0, 1};
      tbl[10] = '{1, 8'hA5, 1, 1, 8'hA5, 0, 1};
      tbl[11] = '{0, 8'hFF, 1, 0, 8'h00, 0, 1};
      tbl[12] = '{0, 8'h55, 1, 0, 8'h00, 0, 1};

      rst = 1'b0;
      m_valid = 1'b0;
      data_in = 8'h00;
      s_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_valid", int'(s_valid), 0);
      chk("rst_s_data", int'(s_data), 0);
      chk("rst_s_last", int'(s_last), 0);
      chk("rst_m_ready", int'(m_ready), 1);
      chk("rst_m_last", int'(m_last), 0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         m_valid = tbl[i].mv;
         data_in = tbl[i].d;
         s_ready = tbl[i].sr;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), int'(s_valid), int'(tbl[i].ev));
         chk($sformatf("vec%0d_m_ready", i), int'(m_ready), int'(tbl[i].emr));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_data", i), int'(s_data), int'(tbl[i].ed));
            chk($sformatf("vec%0d_last", i), int'(s_last), int'(tbl[i].el));
         end
      end

      // Framing: 9 beats, last on beats 4 and 8.
      rst = 1'b0;
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("frm%0d_m_last", i), int'(m_last), int'(i % 4 == 3));
         m_valid = 1'b1;
         data_in = 8'(i + 8'h10);
         s_ready = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("frm%0d_data", i), int'(s_data), i + 8'h10);
         chk($sformatf("frm%0d_s_last", i), int'(s_last), int'(i % 4 == 3));
      end

      // Mid-traffic reset with beats held.
      s_ready = 1'b0;
      data_in = 8'hC3;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_s_valid", int'(s_valid), 0);
      chk("mrst_s_data", int'(s_data), 0);
      chk("mrst_s_last", int'(s_last), 0);
      chk("mrst_m_ready", int'(m_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_valid = 1'b1;
      data_in = 8'h5A;
      s_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_beat0_data", int'(s_data), 8'h5A);
      chk("mrst_beat0_last", int'(s_last), 0);
      m_valid = 1'b0;

      // Random traffic, 100 accepted beats.
      start = acc_all;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         m_valid = ($urandom_range(0, 2) != 0) ^ c[0];
         s_ready = ($urandom_range(0, 2) != 0);
         data_in = 8'($urandom);
         @(posedge clk);
         #1;
         if (acc_all - start >= 100) done = 1'b1;
      end
      chk("rand_done", int'(done), 1);

      // Idle upstream drains within two cycles.
      m_valid = 1'b0;
      s_ready = 1'b1;
      data_in = 8'hEE;
      repeat (2) @(posedge clk);
      #1;
      chk("drain_s_valid", int'(s_valid), 0);
      chk("drain_m_ready", int'(m_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
